bitlet_sel_gen_8: RTL and testbench

- Weight-side scheduler for the Bitlet 8-bit MAC datapath.
- Accepts a vector of VEC_LENGTH signed weights and transposes it into DATA_WIDTH bit-columns.
- Each beat, it emits one activation-select index per bit column: the lowest-index weight whose bit is still set in that column. It then clears that bit.
- Drives the MAC's act_sel/act_val/en/load_accum inputs. Only set weight bits cost cycles.

---
 rtl/bitlet_sel_gen_8.sv | 109 ++++++++++
 tb/tb_bitlet_sel_gen_8.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitlet_sel_gen_8.sv
// Purpose: weight-side Bitlet scheduler; transposes a weight vector into bit columns and
//          emits, per beat, the lowest still-set weight index of every column.
// Latency: first beat valid the cycle after capture; holds all beat outputs while out_ready=0.
module bitlet_sel_gen_8 #(
  parameter int DATA_WIDTH    = 8,
  parameter int VEC_LENGTH    = 8,
  parameter int MUX_SEL_WIDTH = $clog2(VEC_LENGTH),
  parameter int BEAT_WIDTH    = $clog2(VEC_LENGTH + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              w_valid,
  output logic                              w_ready,
  input  logic [VEC_LENGTH*DATA_WIDTH-1:0]  w_in,
  input  logic                              out_ready,
  output logic                              out_valid,
  output logic [DATA_WIDTH*MUX_SEL_WIDTH-1:0] act_sel,
  output logic [DATA_WIDTH-1:0]             act_val,
  output logic                              en,
  output logic                              load_accum,
  output logic                              last,
  output logic [BEAT_WIDTH-1:0]             beat_idx
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state;
  logic [VEC_LENGTH-1:0]   col      [DATA_WIDTH];
  logic [BEAT_WIDTH-1:0]   beat_cnt;

  logic [VEC_LENGTH-1:0]   w_col    [DATA_WIDTH];
  logic [VEC_LENGTH-1:0]   low_bit  [DATA_WIDTH];
  logic [VEC_LENGTH-1:0]   col_next [DATA_WIDTH];
  logic [MUX_SEL_WIDTH-1:0] sel     [DATA_WIDTH];
  logic [DATA_WIDTH-1:0]   col_nz;
  logic [DATA_WIDTH-1:0]   col_rem;
  logic                    run;
  logic                    last_int;
  logic                    capture;

  // Transpose the incoming weights: column j collects bit j of every weight.
  always_comb begin
    for (int j = 0; j < DATA_WIDTH; j++) begin
      w_col[j] = '0;
      for (int i = 0; i < VEC_LENGTH; i++) begin
        w_col[j][i] = w_in[i*DATA_WIDTH + j];
      end
    end
  end

  // Per column: isolate the lowest set bit, what remains after clearing it, and its index.
  always_comb begin
    for (int j = 0; j < DATA_WIDTH; j++) begin
      low_bit[j]  = col[j] & (~col[j] + VEC_LENGTH'(1));
      col_next[j] = col[j] & ~low_bit[j];
      col_nz[j]   = |col[j];
      col_rem[j]  = |col_next[j];
      sel[j]      = '0;
      // Scan from the top so the lowest set index wins; empty columns keep index 0.
      for (int i = VEC_LENGTH - 1; i >= 0; i--) begin
        if (col[j][i]) sel[j] = MUX_SEL_WIDTH'(i);
      end
    end
  end

  // Beat-level outputs decode purely from registered state plus out_ready.
  always_comb begin
    run        = (state == RUN);
    // Last beat when no column still holds a bit after this beat's clear; an
    // all-zero vector therefore produces exactly one (empty) beat.
    last_int   = ~|col_rem;
    out_valid  = run;
    en         = run & out_ready;
    load_accum = run & (beat_cnt == '0);
    last       = run & last_int;
    beat_idx   = beat_cnt;
    w_ready    = ~run | (last_int & out_ready);
    capture    = w_valid & w_ready;
    act_val    = col_nz & {DATA_WIDTH{run}};
    act_sel    = '0;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      act_sel[j*MUX_SEL_WIDTH +: MUX_SEL_WIDTH] = run ? sel[j] : '0;
    end
  end

  // Scheduler state: capture a vector, then peel one bit per column on each accepted beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      for (int j = 0; j < DATA_WIDTH; j++) col[j] <= '0;
    end else if (capture) begin
      // Covers both IDLE capture and the no-bubble handoff on an accepted last beat.
      state    <= RUN;
      beat_cnt <= '0;
      for (int j = 0; j < DATA_WIDTH; j++) col[j] <= w_col[j];
    end else if (en) begin
      for (int j = 0; j < DATA_WIDTH; j++) col[j] <= col_next[j];
      if (last_int) begin
        // Park the counter at zero so IDLE looks the same as after reset.
        state    <= IDLE;
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + BEAT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_bitlet_sel_gen_8.sv
// Bench for bitlet_sel_gen_8: directed scenarios plus randomized vectors with random stalls,
// checked against a column-list model of the scheduling rule.
module tb_bitlet_sel_gen_8;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_valid;
  logic        w_ready;
  logic [63:0] w_in;
  logic        out_ready;
  logic        out_valid;
  logic [23:0] act_sel;
  logic [7:0]  act_val;
  logic        en;
  logic        load_accum;
  logic        last;
  logic [3:0]  beat_idx;

  int n_tests = 0;
  int n_fail  = 0;

  bitlet_sel_gen_8 dut (
    .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready), .w_in(w_in),
    .out_ready(out_ready), .out_valid(out_valid), .act_sel(act_sel), .act_val(act_val),
    .en(en), .load_accum(load_accum), .last(last), .beat_idx(beat_idx)
  );

  always #5 clk = ~clk;

  // Model: column j is the ascending list of weight indices whose bit j is set;
  // beat k hands out the k-th entry of each list, if it has one.
  function automatic logic [31:0] model_beat(input logic [63:0] w, input int k);
    logic [7:0]  val;
    logic [23:0] sel;
    int          lst[$];
    val = '0;
    sel = '0;
    for (int j = 0; j < 8; j++) begin
      lst.delete();
      for (int i = 0; i < 8; i++) if (w[i*8 + j]) lst.push_back(i);
      if (k < lst.size()) begin
        val[j] = 1'b1;
        sel[j*3 +: 3] = 3'(lst[k]);
      end
    end
    return {val, sel};
  endfunction

  function automatic int model_nbeats(input logic [63:0] w);
    int m = 1;
    for (int j = 0; j < 8; j++) begin
      int c = 0;
      for (int i = 0; i < 8; i++) if (w[i*8 + j]) c++;
      if (c > m) m = c;
    end
    return m;
  endfunction

  // Present one vector from IDLE; returns at the negedge where its beat 0 is showing.
  task automatic start_vec(input logic [63:0] w);
    @(negedge clk);
    w_in      = w;
    w_valid   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w_valid   = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; w_valid = 1'b0; out_ready = 1'b0; w_in = '0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if ({out_valid, en, load_accum, last} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctl got %b want 0000", {out_valid, en, load_accum, last});
    end
    n_tests++;
    if (act_val !== 8'h00 || act_sel !== 24'h0 || beat_idx !== 4'd0) begin
      n_fail++; $display("FAIL reset_data got val=%h sel=%h beat=%0d want 0", act_val, act_sel, beat_idx);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if (w_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wready got %b want 1", w_ready); end
  endtask

  task automatic test_ones;
    start_vec(64'h0101010101010101);
    for (int k = 0; k < 8; k++) begin
      out_ready = 1'b1;
      #1;
      n_tests++;
      if (act_val !== 8'h01 || act_sel !== 24'(k) || beat_idx !== 4'(k)) begin
        n_fail++; $display("FAIL ones_beat%0d got val=%h sel=%h beat=%0d want val=01 sel=%h", k, act_val, act_sel, beat_idx, 24'(k));
      end
      n_tests++;
      if (load_accum !== (k == 0) || last !== (k == 7) || en !== 1'b1) begin
        n_fail++; $display("FAIL ones_flags%0d got load=%b last=%b en=%b", k, load_accum, last, en);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sign;
    start_vec(64'h0000810080000000);
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (act_val !== 8'h81 || act_sel !== 24'h600005 || last !== 1'b0 || load_accum !== 1'b1) begin
      n_fail++; $display("FAIL sign_beat0 got val=%h sel=%h last=%b load=%b want 81 600005 0 1", act_val, act_sel, last, load_accum);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (act_val !== 8'h80 || act_sel !== 24'hA00000 || last !== 1'b1 || beat_idx !== 4'd1) begin
      n_fail++; $display("FAIL sign_beat1 got val=%h sel=%h last=%b beat=%0d want 80 a00000 1 1", act_val, act_sel, last, beat_idx);
    end
    @(negedge clk);
  endtask

  task automatic test_zero;
    start_vec(64'h0);
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || act_val !== 8'h00 || act_sel !== 24'h0 || load_accum !== 1'b1 || last !== 1'b1 || en !== 1'b1) begin
      n_fail++; $display("FAIL zero_beat got v=%b val=%h sel=%h load=%b last=%b en=%b", out_valid, act_val, act_sel, load_accum, last, en);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || w_ready !== 1'b1) begin
      n_fail++; $display("FAIL zero_idle got v=%b rdy=%b want 0 1", out_valid, w_ready);
    end
  endtask

  task automatic test_stall;
    logic [23:0] exp_sel;
    int k;
    start_vec({8{8'hFF}});
    k = 0;
    for (int cyc = 0; cyc < 11; cyc++) begin
      out_ready = !(k == 2 && cyc >= 2 && cyc <= 4);
      #1;
      exp_sel = '0;
      for (int j = 0; j < 8; j++) exp_sel[j*3 +: 3] = 3'(k);
      n_tests++;
      if (act_sel !== exp_sel || act_val !== 8'hFF || beat_idx !== 4'(k) || en !== out_ready || last !== (k == 7)) begin
        n_fail++; $display("FAIL stall_c%0d got sel=%h val=%h beat=%0d en=%b last=%b want sel=%h beat=%0d", cyc, act_sel, act_val, beat_idx, en, last, exp_sel, k);
      end
      if (out_ready) k++;
      @(negedge clk);
    end
    #1;
    n_tests++;
    if (k !== 8 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_done got beats=%0d v=%b want 8 0", k, out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] wa, wb;
    logic [31:0] exp;
    int na, nb;
    wa = 64'h0003000100020001;
    wb = {$urandom, $urandom} | 64'h1;
    na = model_nbeats(wa);
    nb = model_nbeats(wb);
    @(negedge clk);
    w_in = wa; w_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w_in = wb;
    for (int k = 0; k < na; k++) begin
      #1;
      n_tests++;
      if (w_ready !== (k == na - 1) || last !== (k == na - 1)) begin
        n_fail++; $display("FAIL b2b_a%0d got rdy=%b last=%b", k, w_ready, last);
      end
      @(negedge clk);
    end
    w_valid = 1'b0;
    for (int k = 0; k < nb; k++) begin
      #1;
      exp = model_beat(wb, k);
      n_tests++;
      if (out_valid !== 1'b1 || load_accum !== (k == 0) || beat_idx !== 4'(k) || {act_val, act_sel} !== exp) begin
        n_fail++; $display("FAIL b2b_b%0d got v=%b load=%b beat=%0d val/sel=%h want %h", k, out_valid, load_accum, beat_idx, {act_val, act_sel}, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] exp;
    logic [63:0] w;
    start_vec({8{8'hFF}});
    for (int k = 0; k < 3; k++) @(negedge clk);
    #1;
    n_tests++;
    if (beat_idx !== 4'd3 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL arst_pre got beat=%0d v=%b want 3 1", beat_idx, out_valid);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || en !== 1'b0 || act_val !== 8'h00) begin
      n_fail++; $display("FAIL arst_drop got v=%b en=%b val=%h want 0 0 00", out_valid, en, act_val);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if (w_ready !== 1'b1 || out_valid !== 1'b0 || beat_idx !== 4'd0) begin
      n_fail++; $display("FAIL arst_idle got rdy=%b v=%b beat=%0d want 1 0 0", w_ready, out_valid, beat_idx);
    end
    w = 64'h0000000000000201;
    start_vec(w);
    for (int k = 0; k < model_nbeats(w); k++) begin
      #1;
      exp = model_beat(w, k);
      n_tests++;
      if (beat_idx !== 4'(k) || {act_val, act_sel} !== exp) begin
        n_fail++; $display("FAIL arst_next%0d got beat=%0d val/sel=%h want %h", k, beat_idx, {act_val, act_sel}, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    logic [63:0] w;
    logic [31:0] exp;
    int nb, k, cyc, d;
    for (int v = 0; v < 40; v++) begin
      d = $urandom_range(0, 3);
      for (int i = 0; i < 8; i++) begin
        case (d)
          0: w[i*8 +: 8] = 8'($urandom);
          1: w[i*8 +: 8] = 8'($urandom) & 8'($urandom);
          2: w[i*8 +: 8] = 8'($urandom) & 8'($urandom) & 8'($urandom);
          default: w[i*8 +: 8] = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
        endcase
      end
      nb = model_nbeats(w);
      start_vec(w);
      k = 0;
      cyc = 0;
      while (k < nb && cyc < 200) begin
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        exp = model_beat(w, k);
        n_tests++;
        if ({act_val, act_sel} !== exp || beat_idx !== 4'(k) || out_valid !== 1'b1) begin
          n_fail++; $display("FAIL rnd%0d_b%0d got val/sel=%h beat=%0d v=%b want %h", v, k, {act_val, act_sel}, beat_idx, out_valid, exp);
        end
        n_tests++;
        if (load_accum !== (k == 0) || last !== (k == nb - 1) || en !== out_ready || w_ready !== ((k == nb - 1) && out_ready)) begin
          n_fail++; $display("FAIL rnd%0d_f%0d got load=%b last=%b en=%b rdy=%b", v, k, load_accum, last, en, w_ready);
        end
        if (out_ready) k++;
        cyc++;
        @(negedge clk);
      end
      if (k < nb) begin
        n_tests++; n_fail++;
        $display("FAIL rnd%0d_timeout got beats=%0d want %0d", v, k, nb);
      end
      #1;
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL rnd%0d_end got v=%b want 0", v, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_sign();
    test_zero();
    test_stall();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
